// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite word SRAM slave (HCLK/HRESET; HSEL,HADDR,HWRITE,HSIZE,HTRANS,HWDATA in; HRDATA,HREADY,HRESP out) with wait states and 2-cycle ERROR
module ahb_lite_sram_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP
);
  typedef enum logic [2:0] {IDLE_ACC, WAIT, DATA, ERR1, ERR2} state_t;
  localparam logic [1:0] WS_LD = 2'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic wr;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic acc, err, unused_trans;
  assign unused_trans = HTRANS[0];
  assign acc = HREADY && HSEL && HTRANS[1];
  assign err = HSIZE != 3'b010 || HADDR[31:ADDR_W] != '0;
  always_comb begin
    HREADY = state inside {IDLE_ACC, DATA, ERR2};
    HRESP = state inside {ERR1, ERR2};
    HRDATA = (state == DATA && !wr) ? mem[idx] : '0;
    state_nx = state == WAIT ? (cnt == 2'd0 ? DATA : WAIT) :
               state == ERR1 ? ERR2 :
               !acc ? IDLE_ACC :
               err ? ERR1 :
               WAIT_STATES > 0 ? WAIT : DATA;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE_ACC;
      cnt <= '0;
      idx <= '0;
      wr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (acc && !err) ? WS_LD : (state == WAIT && cnt != 2'd0) ? cnt - 2'd1 : cnt;
      if (acc) begin
        idx <= HADDR[ADDR_W-1:0];
        wr <= HWRITE && !err;
      end
    end
  end
  always_ff @(posedge HCLK)
    if (!HRESET && state == DATA && wr) mem[idx] <= HWDATA;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: scoreboard bench driving two slaves (0 and 2 wait states) with directed and random AHB-Lite traffic
module tb_ahb_lite_sram_slave;
  typedef struct {bit err; bit chk; logic [31:0] rd;} exp_t;
  int n_cmp = 0;
  int n_bad = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int ln, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t", ln, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WS = g ? 2 : 0;
    logic rst, hsel, hwrite, hready, hresp, done;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0] hsize;
    logic [1:0] htrans;
    exp_t q[$];
    logic [31:0] mdl [256];
    bit known [256];

    ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(WS)) dut (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HRDATA(hrdata),
      .HREADY(hready), .HRESP(hresp)
    );

    // Present one address phase, wait for it to be taken, then drive its write data.
    task automatic issue(input bit sel, input logic [1:0] tr, input bit w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
      int n = 0;
      hsel = sel; htrans = tr; hwrite = w; hsize = sz; haddr = a;
      @(negedge clk);
      while (!hready && n < 8) begin n++; @(negedge clk); end
      check(g, "ready_timeout", hready, 1);
      @(posedge clk); #1;
      hwdata = wd;
      if (sel && tr[1]) begin
        bit e = sz != 3'b010 || a[31:8] != 0;
        exp_t x;
        x.err = e;
        x.chk = e || w || known[a[7:0]];
        x.rd = (!e && !w) ? mdl[a[7:0]] : 32'h0;
        if (!e && w) begin mdl[a[7:0]] = wd; known[a[7:0]] = 1; end
        q.push_back(x);
      end
    endtask

    task automatic idle();
      issue(0, 2'b00, 0, 3'b010, 0, $urandom);
    endtask

    initial begin
      bit in_dp;
      int lows;
      bit side_ok;
      exp_t x;
      in_dp = 0; lows = 0; side_ok = 1;
      forever begin
        @(negedge clk);
        if (rst) begin
          in_dp = 0; lows = 0; side_ok = 1;
          q.delete();
        end else begin
          if (!in_dp) begin
            check(g, "idle_hready", hready, 1);
            check(g, "idle_hresp", hresp, 0);
            check(g, "idle_hrdata", hrdata, 0);
          end else if (!hready) begin
            lows++;
            side_ok &= hrdata == 0 && hresp == (q.size() > 0 && q[0].err);
          end else begin
            check(g, "expect_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
              x = q.pop_front();
              check(g, "wait_cycles", lows, x.err ? 1 : WS);
              check(g, "wait_outputs", side_ok, 1);
              check(g, "hresp", hresp, x.err);
              if (x.chk) check(g, "hrdata", hrdata, x.rd);
            end
            lows = 0; side_ok = 1;
          end
          if (hready) in_dp = hsel && htrans[1];
        end
      end
    end

    initial begin
      int k;
      logic [31:0] a;
      logic [2:0] sz;
      done = 0; rst = 1; hsel = 0; htrans = 0; hwrite = 0; hsize = 3'b010; haddr = 0; hwdata = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      issue(1, 2'b10, 1, 3'b010, 32'h05, 32'hDEADBEEF);
      issue(1, 2'b10, 0, 3'b010, 32'h05, 0);
      idle();
      for (int i = 0; i < 4; i++) issue(1, i ? 2'b11 : 2'b10, 1, 3'b010, 32'h10 + i, 32'h11 * (i + 1));
      for (int i = 0; i < 4; i++) issue(1, i ? 2'b11 : 2'b10, 0, 3'b010, 32'h10 + i, 0);
      idle();
      issue(1, 2'b10, 0, 3'b010, 32'h10, 0);
      issue(1, 2'b10, 1, 3'b010, 32'h00, 32'h0BADF00D);
      issue(1, 2'b10, 1, 3'b010, 32'h100, 32'hFFFFFFFF);
      issue(1, 2'b10, 0, 3'b010, 32'h00, 0);
      issue(1, 2'b10, 1, 3'b001, 32'h00, 32'h12121212);
      issue(1, 2'b10, 0, 3'b010, 32'h00, 0);
      issue(1, 2'b00, 1, 3'b010, 32'h00, 32'h99999999);
      issue(1, 2'b01, 1, 3'b010, 32'h00, 32'h88888888);
      issue(1, 2'b10, 0, 3'b010, 32'h00, 0);
      issue(1, 2'b10, 1, 3'b010, 32'h07, 32'hA5A5A5A5);
      issue(1, 2'b10, 0, 3'b010, 32'h07, 0);
      issue(1, 2'b10, 1, 3'b010, 32'h30, 32'h12345678);
      idle();
      issue(1, 2'b10, 1, 3'b010, 32'h30, 32'hFFFFFFFF);
      hsel = 0; htrans = 0; rst = 1;
      mdl[8'h30] = 32'h12345678;
      @(posedge clk); #1 rst = 0;
      issue(1, 2'b10, 0, 3'b010, 32'h30, 0);
      for (int i = 0; i < 250; i++) begin
        k = $urandom_range(0, 9);
        a = $urandom_range(0, 255);
        sz = 3'b010;
        if ($urandom_range(0, 15) == 0) a = 32'h100 + $urandom_range(0, 1023);
        if ($urandom_range(0, 15) == 0) sz = 3'($urandom_range(0, 7));
        if (k < 5) issue(1, 2'b10, k[0], sz, a, $urandom);
        else if (k < 8) begin
          for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) issue(1, 2'b01, k[0], 3'b010, a + b, $urandom);
            issue(1, b ? 2'b11 : 2'b10, k[0], sz, a + b, $urandom);
          end
        end else issue($urandom_range(0, 1), 2'($urandom_range(0, 1)), k[0], sz, a, $urandom);
      end
      idle();
      repeat (10) @(negedge clk);
      check(g, "queue_drained", q.size(), 0);
      done = 1;
    end
  end

  initial begin
    int t = 0;
    @(posedge clk);
    while (!(lane[0].done && lane[1].done) && t < 60000) begin t++; @(posedge clk); end
    if (!(lane[0].done && lane[1].done)) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: lanes done %0b%0b expected 11", lane[1].done, lane[0].done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
